// File: rtl/bip_pkg.sv
// bip_pkg: opcode, mux-select and state encodings shared by the BIP control unit.
package bip_pkg;
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
    logic       hlt;
    logic       jmp;
    logic       beq;
    logic       bne;
  } dec_t;
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode to datapath-strobe and branch-type decode.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc_i,
  output dec_t             dec_o
);
  always_comb begin
    dec_o = '0;
    case (opc_i)
      OPC_W'(OP_HLT): dec_o.hlt = 1'b1;
      OPC_W'(OP_STO): dec_o.wr_ram = 1'b1;
      OPC_W'(OP_LD): begin
        dec_o.sel_a  = SELA_RAM;
        dec_o.rd_ram = 1'b1;
        dec_o.wr_acc = 1'b1;
      end
      OPC_W'(OP_LDI): begin
        dec_o.sel_a  = SELA_IMM;
        dec_o.wr_acc = 1'b1;
      end
      OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
        dec_o.sel_a  = SELA_ALU;
        dec_o.op     = opc_i == OPC_W'(OP_SUB);
        dec_o.rd_ram = 1'b1;
        dec_o.wr_acc = 1'b1;
      end
      OPC_W'(OP_ADDI), OPC_W'(OP_SUBI): begin
        dec_o.sel_a  = SELA_ALU;
        dec_o.sel_b  = 1'b1;
        dec_o.op     = opc_i == OPC_W'(OP_SUBI);
        dec_o.wr_acc = 1'b1;
      end
      OPC_W'(OP_JMP): dec_o.jmp = 1'b1;
      OPC_W'(OP_BEQ): dec_o.beq = 1'b1;
      OPC_W'(OP_BNE): dec_o.bne = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/bip_control_v2.sv
// bip_control_v2: BIP program counter, run/halt FSM, step gating and instruction counter.
module bip_control_v2
  import bip_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int OPC_W  = 5,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [INST_W-1:0] i_instdata,
  input  logic              i_acc_zero,
  input  logic              i_step_en,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr_pm,
  output logic [ADDR_W-1:0] o_operand,
  output logic [1:0]        o_selA,
  output logic              o_selB,
  output logic              o_wrAcc,
  output logic              o_op,
  output logic              o_wrRam,
  output logic              o_rdRam,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_icount
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [0:0]        st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adv, take;
  dec_t              dec;
  bip_decoder #(.OPC_W(OPC_W)) u_dec (
    .opc_i (i_instdata[INST_W-1 -: OPC_W]),
    .dec_o (dec)
  );
  // reset is folded into adv so an asserted reset kills strobes combinationally
  always_comb begin
    adv      = i_rst && st_q == ST_RUN && (!i_step_en || i_step);
    take     = dec.jmp || (dec.beq && i_acc_zero) || (dec.bne && !i_acc_zero);
    pc_d     = (!adv || dec.hlt) ? pc_q : take ? o_operand : pc_q + ADDR_W'(1);
    st_d     = (adv && dec.hlt) ? ST_HALT : st_q;
    cnt_d    = (adv && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    o_selA   = adv ? dec.sel_a : SELA_RAM;
    o_selB   = adv && dec.sel_b;
    o_wrAcc  = adv && dec.wr_acc;
    o_op     = adv && dec.op;
    o_wrRam  = adv && dec.wr_ram;
    o_rdRam  = adv && dec.rd_ram;
  end
  assign o_operand = i_instdata[ADDR_W-1:0];
  assign o_addr_pm = pc_q;
  assign o_halted  = st_q == ST_HALT;
  assign o_icount  = cnt_q;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q  <= '0;
      st_q  <= ST_RUN;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
